// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared state encoding, op codes and sizing helper for the mul/div sequencer
package muldiv_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_PREP = 3'd1;
  localparam state_t ST_ITER = 3'd2;
  localparam state_t ST_FIX  = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// rtl/muldiv_negate.sv - combinational conditional two's-complement negate
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - radix-2 iterative signed multiply/divide with its own sequencing FSM
// Optional MUL early-out when the remaining multiplier bits are zero: MULDIV_EARLY_OUT_EN.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t            state_q, state_d;
  logic              op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  mq_q, mq_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH-1:0]   a_abs, b_abs, rem_fix;
  logic [2*WIDTH-1:0] fix_in, prod_fix;

  muldiv_negate #(.W(WIDTH)) u_abs_a (.value(a_q), .negate(a_q[WIDTH-1]), .result(a_abs));
  muldiv_negate #(.W(WIDTH)) u_abs_b (.value(b_q), .negate(b_q[WIDTH-1]), .result(b_abs));

  // MUL corrects the full product; DIV reuses the low half for the quotient.
  assign fix_in = (op_q == OP_MUL) ? {acc_q, mq_q} : {{WIDTH{1'b0}}, mq_q};
  muldiv_negate #(.W(2*WIDTH)) u_fix_prod (.value(fix_in), .negate(sign_a_q ^ sign_b_q), .result(prod_fix));
  muldiv_negate #(.W(WIDTH)) u_fix_rem (.value(acc_q), .negate(sign_a_q), .result(rem_fix));

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;

  assign mul_sum  = mq_q[0] ? ({1'b0, acc_q} + {1'b0, opnd_q}) : {1'b0, acc_q};
  assign mul_prod = {mul_sum, mq_q[WIDTH-1:1]};
  assign div_sh   = {acc_q, mq_q[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, opnd_q};
  assign div_diff = div_sh[WIDTH-1:0] - opnd_q;

`ifdef MULDIV_EARLY_OUT_EN
  logic [CW:0]        steps_done, skip;
  logic [WIDTH-1:0]   rest_mask;
  logic               early;
  logic [2*WIDTH-1:0] prod_skipped;

  assign steps_done   = {1'b0, count_q} + (CW+1)'(1);
  assign skip         = (CW+1)'(WIDTH - 1) - {1'b0, count_q};
  assign rest_mask    = {WIDTH{1'b1}} >> steps_done;
  assign early        = (op_q == OP_MUL) && ((mul_prod[WIDTH-1:0] & rest_mask) == '0);
  assign prod_skipped = mul_prod >> skip;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_PREP;
          op_d    = op;
          a_d     = a;
          b_d     = b;
          dbz_d   = 1'b0;
        end
      end
      ST_PREP: begin
        sign_a_d = a_q[WIDTH-1];
        sign_b_d = b_q[WIDTH-1];
        acc_d    = '0;
        count_d  = '0;
        opnd_d   = (op_q == OP_MUL) ? a_abs : b_abs;
        mq_d     = (op_q == OP_MUL) ? b_abs : a_abs;
        state_d  = ST_ITER;
        // Divide-by-zero results are final here; FIX is only a pass-through cycle.
        if (op_q == OP_DIV && b_q == '0) begin
          hi_d    = a_q;
          lo_d    = '1;
          dbz_d   = 1'b1;
          state_d = ST_FIX;
        end
      end
      ST_ITER: begin
        count_d = count_q + CW'(1);
        if (op_q == OP_MUL) begin
          acc_d = mul_prod[2*WIDTH-1:WIDTH];
          mq_d  = mul_prod[WIDTH-1:0];
        end else begin
          acc_d = div_ge ? div_diff : div_sh[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], div_ge};
        end
        if (count_q == LAST_CNT) state_d = ST_FIX;
`ifdef MULDIV_EARLY_OUT_EN
        if (early) begin
          acc_d   = prod_skipped[2*WIDTH-1:WIDTH];
          mq_d    = prod_skipped[WIDTH-1:0];
          state_d = ST_FIX;
        end
`endif
      end
      ST_FIX: begin
        if (!dbz_q) begin
          hi_d = (op_q == OP_MUL) ? prod_fix[2*WIDTH-1:WIDTH] : rem_fix;
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
  assign done        = (state_q == ST_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
